// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I core with 64 KiB byte memory and flat M-mode CSRs.
// Define CORE_TRACE_EN to print a per-instruction execution trace in simulation.

module rv32i_mem (
    input  logic        clk,
    input  logic [15:0] if_addr,
    output logic [31:0] if_data,
    input  logic [15:0] ld_addr,
    output logic [31:0] ld_data,
    input  logic [15:0] st_addr,
    input  logic [3:0]  st_be,
    input  logic [31:0] st_data
);
    logic [7:0] m [0:65535];

    // Byte lanes wrap at 64 KiB, so misaligned words straddle the top cleanly.
    always_comb begin
        if_data = {m[if_addr + 16'd3], m[if_addr + 16'd2],
                   m[if_addr + 16'd1], m[if_addr]};
        ld_data = {m[ld_addr + 16'd3], m[ld_addr + 16'd2],
                   m[ld_addr + 16'd1], m[ld_addr]};
    end

    always_ff @(posedge clk) begin
        if (st_be[0]) m[st_addr]         <= st_data[7:0];
        if (st_be[1]) m[st_addr + 16'd1] <= st_data[15:8];
        if (st_be[2]) m[st_addr + 16'd2] <= st_data[23:16];
        if (st_be[3]) m[st_addr + 16'd3] <= st_data[31:24];
    end
endmodule

module rv32i_core (
    input logic clk,
    input logic rst
);
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] rs  [0:31];
    logic [31:0] csr [0:4095];

    logic [31:0] instr;
    logic [31:0] ld_data;
    logic [31:0] ld_addr;
    logic [31:0] st_addr;
    logic [3:0]  st_be;
    logic [31:0] st_data;

    rv32i_mem memory (
        .clk     (clk),
        .if_addr (pc[15:0]),
        .if_data (instr),
        .ld_addr (ld_addr[15:0]),
        .ld_data (ld_data),
        .st_addr (st_addr[15:0]),
        .st_be   (st_be),
        .st_data (st_data)
    );

    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [2:0]  f3;
    logic        alt;
    logic [11:0] csr_a;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] rv1;
    logic [31:0] rv2;

    assign opc   = instr[6:0];
    assign rd    = instr[11:7];
    assign f3    = instr[14:12];
    assign ra    = instr[19:15];
    assign rb    = instr[24:20];
    assign alt   = instr[30];
    assign csr_a = instr[31:20];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25],
                    instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20],
                    instr[30:21], 1'b0};
    assign rv1   = (ra == 5'd0) ? 32'd0 : rs[ra];
    assign rv2   = (rb == 5'd0) ? 32'd0 : rs[rb];

    assign ld_addr = rv1 + imm_i;
    assign st_addr = rv1 + imm_s;
    assign st_data = rv2;

    logic unused_addr;
    assign unused_addr = ^{ld_addr[31:16], st_addr[31:16]};

    logic is_lui;
    logic is_auipc;
    logic is_jal;
    logic is_jalr;
    logic is_br;
    logic is_ld;
    logic is_st;
    logic is_opi;
    logic is_op;
    logic is_sys;

    assign is_lui   = (opc == 7'h37);
    assign is_auipc = (opc == 7'h17);
    assign is_jal   = (opc == 7'h6f);
    assign is_jalr  = (opc == 7'h67);
    assign is_br    = (opc == 7'h63);
    assign is_ld    = (opc == 7'h03);
    assign is_st    = (opc == 7'h23);
    assign is_opi   = (opc == 7'h13);
    assign is_op    = (opc == 7'h33);
    assign is_sys   = (opc == 7'h73);

    logic [31:0] alu_b;
    logic [31:0] alu_y;

    always_comb begin
        alu_b = is_op ? rv2 : imm_i;
        unique case (f3)
            3'd0: alu_y = (is_op && alt) ? rv1 - alu_b : rv1 + alu_b;
            3'd1: alu_y = rv1 << alu_b[4:0];
            3'd2: alu_y = {31'd0, $signed(rv1) < $signed(alu_b)};
            3'd3: alu_y = {31'd0, rv1 < alu_b};
            3'd4: alu_y = rv1 ^ alu_b;
            3'd5: alu_y = alt ? 32'($signed(rv1) >>> alu_b[4:0])
                              : rv1 >> alu_b[4:0];
            3'd6: alu_y = rv1 | alu_b;
            3'd7: alu_y = rv1 & alu_b;
        endcase
    end

    logic br_take;

    always_comb begin
        unique case (f3)
            3'd0:    br_take = (rv1 == rv2);
            3'd1:    br_take = (rv1 != rv2);
            3'd4:    br_take = ($signed(rv1) <  $signed(rv2));
            3'd5:    br_take = ($signed(rv1) >= $signed(rv2));
            3'd6:    br_take = (rv1 <  rv2);
            3'd7:    br_take = (rv1 >= rv2);
            default: br_take = 1'b0;
        endcase
    end

    logic        ld_ok;
    logic [31:0] ld_val;

    always_comb begin
        ld_ok = 1'b1;
        unique case (f3)
            3'd0:    ld_val = {{24{ld_data[7]}}, ld_data[7:0]};
            3'd1:    ld_val = {{16{ld_data[15]}}, ld_data[15:0]};
            3'd2:    ld_val = ld_data;
            3'd4:    ld_val = {24'd0, ld_data[7:0]};
            3'd5:    ld_val = {16'd0, ld_data[15:0]};
            default: begin
                ld_val = 32'd0;
                ld_ok  = 1'b0;
            end
        endcase
    end

    logic [31:0] csr_old;
    logic [31:0] csr_src;

    assign csr_old = (csr_a == 12'hf14) ? 32'd0 : csr[csr_a];
    assign csr_src = f3[2] ? {27'd0, ra} : rv1;

    logic        rd_we;
    logic [31:0] rd_val;
    logic        csr_we;
    logic [31:0] csr_wv;
    logic        trap;
    logic [31:0] cause;

    always_comb begin
        pc_d   = pc + 32'd4;
        rd_we  = 1'b0;
        rd_val = 32'd0;
        st_be  = 4'd0;
        csr_we = 1'b0;
        csr_wv = 32'd0;
        trap   = 1'b0;
        cause  = 32'd0;
        unique case (1'b1)
            is_lui: begin
                rd_we  = 1'b1;
                rd_val = imm_u;
            end
            is_auipc: begin
                rd_we  = 1'b1;
                rd_val = pc + imm_u;
            end
            is_jal: begin
                rd_we  = 1'b1;
                rd_val = pc + 32'd4;
                pc_d   = pc + imm_j;
            end
            is_jalr: begin
                rd_we  = 1'b1;
                rd_val = pc + 32'd4;
                pc_d   = (rv1 + imm_i) & ~32'd1;
            end
            is_br: begin
                if (br_take) pc_d = pc + imm_b;
            end
            is_ld: begin
                rd_we  = ld_ok;
                rd_val = ld_val;
            end
            is_st: begin
                unique case (f3)
                    3'd0:    st_be = 4'b0001;
                    3'd1:    st_be = 4'b0011;
                    3'd2:    st_be = 4'b1111;
                    default: st_be = 4'd0;
                endcase
            end
            is_opi, is_op: begin
                rd_we  = 1'b1;
                rd_val = alu_y;
            end
            is_sys: begin
                if (f3 == 3'd0) begin
                    if (csr_a == 12'h000) begin
                        trap  = 1'b1;
                        cause = 32'd11;
                    end else if (csr_a == 12'h001) begin
                        trap  = 1'b1;
                        cause = 32'd3;
                    end else if (csr_a == 12'h302) begin
                        pc_d = csr[12'h341];
                    end
                end else if (f3 != 3'd4) begin
                    rd_we  = 1'b1;
                    rd_val = csr_old;
                    unique case (f3[1:0])
                        2'd1: begin
                            csr_we = 1'b1;
                            csr_wv = csr_src;
                        end
                        2'd2: begin
                            csr_we = (ra != 5'd0);
                            csr_wv = csr_old | csr_src;
                        end
                        default: begin
                            csr_we = (ra != 5'd0);
                            csr_wv = csr_old & ~csr_src;
                        end
                    endcase
                end
            end
            default: ;
        endcase
        if (trap) pc_d = csr[12'h305] & ~32'd3;
        // Memory has no reset, so stores are suppressed while reset is held.
        if (!rst) st_be = 4'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= 32'd0;
        else      pc <= pc_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rs[i] <= 32'd0;
        end else if (rd_we && rd != 5'd0) begin
            rs[rd] <= rd_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4096; i++) csr[i] <= 32'd0;
        end else if (trap) begin
            csr[12'h341] <= pc;
            csr[12'h342] <= cause;
        end else if (csr_we) begin
            csr[csr_a] <= csr_wv;
        end
    end

`ifdef CORE_TRACE_EN
    always @(posedge clk) begin
        if (rst) begin
            if (rd_we && rd != 5'd0)
                $display("pc=%08h insn=%08h x%0d=%08h", pc, instr, rd, rd_val);
            else
                $display("pc=%08h insn=%08h", pc, instr);
        end
    end
`endif
endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed and random programs checked against an instruction-level model.
module tb_rv32i_core;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rv32i_core dut (
        .clk (clk),
        .rst (rst)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mpc;
    logic [31:0] mx   [32];
    logic [31:0] mcsr [4096];
    logic [7:0]  mm   [65536];

    function automatic logic [31:0] e_i(int op, int rd, int f3, int r1, int imm);
        return {imm[11:0], r1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] e_r(int rd, int f3, int r1, int r2, int f7);
        return {f7[6:0], r2[4:0], r1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] e_s(int f3, int r1, int r2, int imm);
        return {imm[11:5], r2[4:0], r1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] e_b(int f3, int r1, int r2, int imm);
        return {imm[12], imm[10:5], r2[4:0], r1[4:0], f3[2:0],
                imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] e_u(int op, int rd, int imm);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] e_j(int rd, int imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] m_word(logic [31:0] a);
        logic [15:0] b;
        b = a[15:0];
        return {mm[b + 16'd3], mm[b + 16'd2], mm[b + 16'd1], mm[b]};
    endfunction

    function automatic logic [31:0] m_alu(int f3, logic [31:0] a,
                                          logic [31:0] b, bit sub_sra);
        case (f3)
            0: return sub_sra ? a - b : a + b;
            1: return a << b[4:0];
            2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3: return (a < b) ? 32'd1 : 32'd0;
            4: return a ^ b;
            5: return sub_sra ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic m_reset();
        mpc = 32'd0;
        for (int i = 0; i < 32; i++) mx[i] = 32'd0;
        for (int i = 0; i < 4096; i++) mcsr[i] = 32'd0;
    endtask

    // One architectural step of the reference ISS.
    task automatic m_step();
        logic [31:0] ins, a, b, r, nx, ii, is_, ib, iu, ij, ea, ld, old, src;
        int op, f3, rd, r1, r2, csa, nb;
        bit wr, tk;
        ins = m_word(mpc);
        op  = int'(ins[6:0]);
        rd  = int'(ins[11:7]);
        f3  = int'(ins[14:12]);
        r1  = int'(ins[19:15]);
        r2  = int'(ins[24:20]);
        csa = int'(ins[31:20]);
        a   = mx[r1];
        b   = mx[r2];
        ii  = 32'($signed(ins[31:20]));
        is_ = 32'($signed({ins[31:25], ins[11:7]}));
        ib  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        iu  = {ins[31:12], 12'd0};
        ij  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        nx  = mpc + 4;
        wr  = 0;
        r   = 0;
        case (op)
            'h37: begin r = iu; wr = 1; end
            'h17: begin r = mpc + iu; wr = 1; end
            'h6f: begin r = mpc + 4; wr = 1; nx = mpc + ij; end
            'h67: begin r = mpc + 4; wr = 1; nx = (a + ii) & 32'hffff_fffe; end
            'h63: begin
                case (f3)
                    0: tk = (a == b);
                    1: tk = (a != b);
                    4: tk = ($signed(a) < $signed(b));
                    5: tk = ($signed(a) >= $signed(b));
                    6: tk = (a < b);
                    7: tk = (a >= b);
                    default: tk = 0;
                endcase
                if (tk) nx = mpc + ib;
            end
            'h03: begin
                ea = a + ii;
                ld = m_word(ea);
                wr = 1;
                case (f3)
                    0: r = 32'($signed(ld[7:0]));
                    1: r = 32'($signed(ld[15:0]));
                    2: r = ld;
                    4: r = {24'd0, ld[7:0]};
                    5: r = {16'd0, ld[15:0]};
                    default: wr = 0;
                endcase
            end
            'h23: begin
                ea = a + is_;
                nb = (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 2) ? 4 : 0;
                for (int k = 0; k < nb; k++) mm[16'(ea + k)] = b[8*k +: 8];
            end
            'h13: begin r = m_alu(f3, a, ii, (f3 == 5) && ins[30]); wr = 1; end
            'h33: begin r = m_alu(f3, a, b, ins[30]); wr = 1; end
            'h73: begin
                if (f3 == 0) begin
                    if (csa == 0 || csa == 1) begin
                        nx = mcsr['h305] & ~32'd3;
                        mcsr['h341] = mpc;
                        mcsr['h342] = (csa == 0) ? 32'd11 : 32'd3;
                    end else if (csa == 'h302) begin
                        nx = mcsr['h341];
                    end
                end else if (f3 != 4) begin
                    old = (csa == 'hf14) ? 32'd0 : mcsr[csa];
                    src = (f3 >= 4) ? 32'(r1) : a;
                    r = old;
                    wr = 1;
                    case (f3 % 4)
                        1: mcsr[csa] = src;
                        2: if (r1 != 0) mcsr[csa] = old | src;
                        default: if (r1 != 0) mcsr[csa] = old & ~src;
                    endcase
                end
            end
            default: ;
        endcase
        if (wr && rd != 0) mx[rd] = r;
        mpc = nx;
    endtask

    task automatic lit(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", name, got, want);
        end
    endtask

    task automatic check_state(string tag);
        int bad_r;
        int ca [4] = '{'h305, 'h340, 'h341, 'h342};
        lit({tag, "_pc"}, dut.pc, mpc);
        bad_r = -1;
        for (int i = 0; i < 32; i++)
            if (bad_r < 0 && dut.rs[i] !== mx[i]) bad_r = i;
        n_cmp++;
        if (bad_r >= 0) begin
            n_bad++;
            $display("FAIL %s_x%0d: got %08h want %08h", tag, bad_r,
                     dut.rs[bad_r], mx[bad_r]);
        end
        for (int i = 0; i < 4; i++)
            lit($sformatf("%s_csr%03h", tag, ca[i]), dut.csr[ca[i]], mcsr[ca[i]]);
    endtask

    task automatic mem_check(string tag);
        int bad_a;
        bad_a = -1;
        for (int i = 0; i < 'h2000; i++)
            if (bad_a < 0 && dut.memory.m[i] !== mm[i]) bad_a = i;
        n_cmp++;
        if (bad_a >= 0) begin
            n_bad++;
            $display("FAIL %s_mem[%04h]: got %02h want %02h", tag, bad_a,
                     dut.memory.m[bad_a], mm[bad_a]);
        end
    endtask

    task automatic begin_prog();
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        for (int i = 0; i < 'h2000; i++) begin
            dut.memory.m[i] = 8'd0;
            mm[i] = 8'd0;
        end
    endtask

    task automatic put(int addr, logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            dut.memory.m[addr + k] = w[8*k +: 8];
            mm[addr + k] = w[8*k +: 8];
        end
    endtask

    task automatic go();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run(int n, string tag);
        repeat (n) begin
            @(posedge clk);
            m_step();
            @(negedge clk);
            check_state(tag);
        end
    endtask

    task automatic rand_prog();
        int n, kind, rd, r1, r2, f3, imm;
        int ldf [5]  = '{0, 1, 2, 4, 5};
        int csf [6]  = '{1, 2, 3, 5, 6, 7};
        int csad [3] = '{'h340, 'h305, 'hf14};
        n = 48;
        begin_prog();
        put(0, e_u('h37, 28, 1));
        for (int i = 1; i < n - 1; i++) begin
            kind = $urandom_range(0, 11);
            rd = $urandom_range(1, 27);
            r1 = $urandom_range(0, 28);
            r2 = $urandom_range(0, 28);
            f3 = $urandom_range(0, 7);
            imm = $urandom;
            if (kind == 9 && i > n - 3) kind = 3;
            case (kind)
                0, 1: put(4*i, e_u('h37, rd, imm));
                2: put(4*i, e_u('h17, rd, imm));
                3, 4: begin
                    if (f3 == 1) imm = imm % 32;
                    if (f3 == 5) imm = (imm % 32) | (($urandom % 2) * 'h400);
                    put(4*i, e_i('h13, rd, f3, r1, imm));
                end
                5, 6: put(4*i, e_r(rd, f3, r1, r2,
                          ((f3 == 0 || f3 == 5) && $urandom % 2) ? 'h20 : 0));
                7: put(4*i, e_i('h03, rd, ldf[$urandom_range(0, 4)], 28,
                                $urandom_range(0, 255)));
                8: put(4*i, e_s($urandom_range(0, 2), 28, r2,
                                $urandom_range(0, 255)));
                9: put(4*i, e_b(f3, r1, r2, 8));
                10: put(4*i, e_i('h73, rd, csf[$urandom_range(0, 5)], r1,
                                 csad[$urandom_range(0, 2)]));
                default: begin
                    if (f3 < 3) put(4*i, e_j(rd, 8));
                    else if (f3 < 5) put(4*i, {imm[31:7], 7'h00});
                    else put(4*i, 32'h0ff0000f);
                end
            endcase
        end
        put(4*(n - 1), e_j(0, 0));
        go();
    endtask

    initial begin
        repeat (2) @(negedge clk);

        // ALU and LUI
        begin_prog();
        put(0, e_u('h37, 1, 'h12345));
        put(4, e_i('h13, 1, 0, 1, 'h678));
        put(8, e_i('h13, 2, 5, 1, 'h404));
        put(12, e_j(0, 0));
        #1;
        lit("reset_pc", dut.pc, 32'd0);
        check_state("reset");
        go();
        run(3, "alu");
        lit("alu_x1", dut.rs[1], 32'h12345678);
        lit("alu_x2", dut.rs[2], 32'h01234567);
        lit("model_x2", mx[2], 32'h01234567);

        // JALR with odd target
        begin_prog();
        put(0, e_i('h13, 6, 0, 0, 'h100));
        for (int i = 1; i < 4; i++) put(4*i, e_i('h13, 0, 0, 0, 0));
        put('h10, e_i('h67, 5, 0, 6, 3));
        go();
        run(5, "jalr");
        lit("jalr_pc", dut.pc, 32'h102);
        lit("jalr_x5", dut.rs[5], 32'h14);

        // Store then loads, including load right after store
        begin_prog();
        put(0, e_u('h37, 1, 'h80ff8));
        put(4, e_i('h13, 1, 0, 1, -255));
        put(8, e_i('h13, 2, 0, 0, 'h200));
        put(12, e_s(2, 2, 1, 0));
        put(16, e_i('h03, 3, 0, 2, 0));
        put(20, e_i('h03, 4, 0, 2, 3));
        put(24, e_i('h03, 5, 5, 2, 2));
        put(28, e_j(0, 0));
        go();
        run(7, "ldst");
        lit("lb_200", dut.rs[3], 32'h00000001);
        lit("lb_203", dut.rs[4], 32'hffffff80);
        lit("lhu_202", dut.rs[5], 32'h000080ff);
        mem_check("ldst");

        // ECALL / MRET round trip
        begin_prog();
        put(0, e_j(0, 'h40));
        put(4, 32'h30200073);
        put('h40, e_i('h13, 1, 0, 0, 4));
        put('h44, e_i('h73, 0, 1, 1, 'h305));
        put('h48, e_j(0, 'h38));
        put('h80, 32'h00000073);
        go();
        run(5, "trap");
        lit("ecall_pc", dut.pc, 32'h4);
        lit("ecall_mepc", dut.csr['h341], 32'h80);
        lit("ecall_mcause", dut.csr['h342], 32'd11);
        run(1, "mret");
        lit("mret_pc", dut.pc, 32'h80);

        // Reset held for two cycles after the program has run
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        lit("hold_pc", dut.pc, 32'd0);
        check_state("hold");
        lit("hold_mtvec", dut.csr['h305], 32'd0);
        mem_check("hold");

        // Random programs; one gets an asynchronous mid-program reset
        for (int p = 0; p < 10; p++) begin
            rand_prog();
            if (p == 3) begin
                run(20, "rnd");
                @(posedge clk);
                #2 rst = 1'b0;
                #1 lit("async_pc", dut.pc, 32'd0);
                m_reset();
                @(negedge clk);
                rst = 1'b1;
            end
            run(70, "rnd");
            mem_check("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rv32i_core.md
# rv32i_core

Single-cycle RV32I processor with integrated 64 KiB byte-addressed memory, 32-entry integer register file and a flat machine-mode CSR file. Top-level compute block of the simulation environment: the bench preloads memory by hierarchical `$readmemh` into `memory.m` and judges results by probing `pc` and `rs[3]`. Executes one instruction per clock and supports the machine-mode subset needed by riscv-tests `-p` programs: CSR access, ECALL and MRET.

## Interface
- No parameters.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- No other ports.
- Bench-visible hierarchy, names fixed:
  - `pc`: 32-bit register.
  - `rs[0:31]`: 32-bit registers.
  - `csr[0:4095]`: 32-bit registers.
  - Instance `memory` containing `m[0:65535]`: 8-bit entries.

## Operation
- Fetch:
  - Instruction = {m[pc+3], m[pc+2], m[pc+1], m[pc]}, little-endian.
  - Addresses use bits [15:0]; upper bits are ignored, so addresses wrap at 64 KiB.
- Decode and execute all RV32I base instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, the ALU-immediate group, the ALU-register group, FENCE, ECALL, EBREAK, MRET and CSRRW/S/C/WI/SI/CI.
- Next PC:
  - Default pc+4.
  - JAL: pc+imm.
  - JALR: (rs1+imm) & ~1.
  - Taken branch: pc+imm.
  - Link value for JAL/JALR is pc+4.
  - Branch and jump targets are not alignment-checked.
- Register file:
  - `rs[0]` always reads 0; writes to it are discarded.
  - Reads are combinational; writes occur at the rising edge.
- Loads:
  - Combinational byte read.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Misaligned accesses are performed byte-wise with no trap.
- Stores:
  - Write 1/2/4 bytes at the rising edge.
  - A store followed by a load to the same address on the next cycle returns the new data.
- Shifts use the low 5 bits of the shift amount. SRA/SRAI are arithmetic. SLT/SLTI are signed; SLTU/SLTIU are unsigned.
- CSR instructions:
  - Read the old `csr[imm[11:0]]` into rd, then write the new value.
  - CSRRS/CSRRC with rs1=x0 (or zimm=0) do not write the CSR.
  - All 4096 addresses are plain read/write storage; mhartid (0xF14) reads 0.
- ECALL: mepc(0x341) ← pc, mcause(0x342) ← 11, pc ← mtvec(0x305) & ~3.
- EBREAK: same as ECALL but mcause ← 3.
- MRET: pc ← mepc.
- FENCE/FENCE.I execute as no-ops.
- Any undecodable opcode executes as a no-op (pc+4) with no trap.

## Timing
- Latency: one instruction per cycle; the architectural effect of the instruction at `pc` is visible after the next rising edge.
- Reset (rst=0, asynchronous):
  - `pc` = 0, all `rs` = 0, all `csr` = 0.
  - Memory contents are not affected.
- While rst=0 no instruction executes and no memory write occurs.
- Execution starts at the first rising edge after rst returns to 1, fetching from address 0.
- Reset asserted mid-program immediately returns `pc` to 0. A store coincident with reset assertion is dropped.
- Simultaneous events:
  - If rd = rs1 in one instruction, the old value is used for the operation.
  - For CSR read-modify-write, rd receives the pre-write CSR value.

## Configuration
- `CORE_TRACE_EN`:
  - Defined: each rising edge with rst=1 prints `$display` of pc, instruction word, and rd index/value when a register is written. Simulation-only; no functional change.
  - Undefined: no trace logic or output is compiled in.

## Test plan
- Reset: hold rst=0 for 2 cycles after a program has run → pc=0, rs[1..31]=0, csr[0x305]=0, memory unchanged.
- ALU/LUI: program `lui x1,0x12345; addi x1,x1,0x678; srai x2,x1,4` → rs[1]=0x12345678, rs[2]=0x01234567 after 3 cycles.
- JALR: at pc=0x10 `jalr x5,3(x6)` with rs[6]=0x100 → pc=0x102, rs[5]=0x14.
- Load/store: `sw` 0x80FF7F01 to 0x200, then `lb` 0x200 → 0x00000001; `lb` 0x203 → 0xFFFFFF80; `lhu` 0x202 → 0x80FF.
- Trap round-trip: csrw mtvec=0x4, ecall at pc=0x80 → pc=0x4, csr[0x341]=0x80, csr[0x342]=11; then mret → pc=0x80.
- Compliance: load rv32ui-p-jalr (and other rv32ui-p images) → pc reaches 0x44 with rs[3]=1 within 5000 cycles.
